// File: rtl/sparce_pkg.sv
// Shared SparCE types: PSRU state encoding, the latched SASA entry and the instruction size.
package sparce_pkg;

  localparam int SPARCE_INSTR_BYTES = 4;
  localparam int SPARCE_SKIP_W      = 5;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CHECK    = 2'd1,
    WAIT     = 2'd2,
    REDIRECT = 2'd3
  } psru_state_t;

  typedef struct packed {
    logic [4:0]               rs1;
    logic [4:0]               rs2;
    logic                     cond;
    logic [SPARCE_SKIP_W-1:0] skip_cnt;
  } sasa_entry_t;

  // cond = 1 needs both sources sparse, cond = 0 needs either.
  function automatic logic sparce_match(input logic cond, input logic s1, input logic s2);
    return cond ? (s1 & s2) : (s1 | s2);
  endfunction

endpackage

// File: rtl/sparce_psru_hazard.sv
// Combinational check: does an in-flight instruction still owe a sparsity writeback to rs1/rs2?
module sparce_psru_hazard (
  input  logic       inflight_valid,
  input  logic [4:0] inflight_rd,
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  output logic       hazard
);

  // x0 is never written, so it can never be a pending source.
  assign hazard = inflight_valid && (inflight_rd != 5'd0) &&
                  ((inflight_rd == rs1) || (inflight_rd == rs2));

endmodule

// File: rtl/sparce_psru.sv
// SparCE pre-identify-and-skip redundancy unit: latches a SASA hit, checks SpRF sparsity, redirects fetch.
// Optional statistics counters are enabled with the SPARCE_PSRU_STATS_EN macro.
module sparce_psru
  import sparce_pkg::*;
#(
  parameter int MAX_WAIT = 3,
  parameter int SKIP_W   = 5
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic [31:0]       pc,
  input  logic              sasa_hit,
  input  logic [4:0]        sasa_rs1_in,
  input  logic [4:0]        sasa_rs2_in,
  input  logic              sasa_cond,
  input  logic [SKIP_W-1:0] sasa_skip_cnt,
  input  logic              inflight_valid,
  input  logic [4:0]        inflight_rd,
  input  logic              rs1_sparsity,
  input  logic              rs2_sparsity,
  input  logic              flush,
  input  logic              skip_ack,
  output logic [4:0]        sasa_rs1,
  output logic [4:0]        sasa_rs2,
  output logic              skip,
  output logic [31:0]       skip_target,
  output logic              busy
`ifdef SPARCE_PSRU_STATS_EN
  ,
  output logic [31:0]       skip_count,
  output logic [31:0]       abort_count
`endif
);

  localparam int WAIT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

  psru_state_t       state_q, state_d;
  sasa_entry_t       entry_q, entry_d;
  logic [31:0]       lpc_q, lpc_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              hazard;
  logic              match;
  logic              wait_timeout;

  sparce_psru_hazard u_hazard (
    .inflight_valid (inflight_valid),
    .inflight_rd    (inflight_rd),
    .rs1            (entry_q.rs1),
    .rs2            (entry_q.rs2),
    .hazard         (hazard)
  );

  assign match        = sparce_match(entry_q.cond, rs1_sparsity, rs2_sparsity);
  assign wait_timeout = (state_q == WAIT) && hazard && (wait_cnt_q == WAIT_W'(MAX_WAIT));

  always_comb begin
    state_d    = state_q;
    entry_d    = entry_q;
    lpc_d      = lpc_q;
    wait_cnt_d = wait_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (sasa_hit) begin
          lpc_d            = pc;
          entry_d.rs1      = sasa_rs1_in;
          entry_d.rs2      = sasa_rs2_in;
          entry_d.cond     = sasa_cond;
          // The stored field is sized by the package; SKIP_W is expected to match it.
          entry_d.skip_cnt = SPARCE_SKIP_W'(sasa_skip_cnt);
          wait_cnt_d       = '0;
          state_d          = CHECK;
        end
      end
      CHECK, WAIT: begin
        if (hazard) begin
          if (state_q == CHECK) begin
            state_d    = (MAX_WAIT > 0) ? WAIT : IDLE;
            wait_cnt_d = WAIT_W'(1);
          end else if (wait_timeout) begin
            state_d = IDLE;
          end else begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
          end
        end else if (match && (entry_q.skip_cnt != '0)) begin
          state_d = REDIRECT;
        end else begin
          state_d = IDLE;
        end
      end
      REDIRECT: begin
        if (skip_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= IDLE;
      entry_q    <= '0;
      lpc_q      <= '0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      entry_q    <= entry_d;
      lpc_q      <= lpc_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign sasa_rs1    = entry_q.rs1;
  assign sasa_rs2    = entry_q.rs2;
  assign busy        = (state_q != IDLE);
  assign skip        = (state_q == REDIRECT) && !flush;
  assign skip_target = (state_q == REDIRECT) ?
                       lpc_q + ((32'(entry_q.skip_cnt) + 32'd1) * 32'(SPARCE_INSTR_BYTES)) : 32'd0;

`ifdef SPARCE_PSRU_STATS_EN
  logic [31:0] skip_count_q, skip_count_d;
  logic [31:0] abort_count_q, abort_count_d;

  always_comb begin
    skip_count_d  = skip_count_q;
    abort_count_d = abort_count_q;
    if ((state_q == REDIRECT) && skip_ack && !flush && (skip_count_q != '1))
      skip_count_d = skip_count_q + 32'd1;
    if (wait_timeout && !flush && (abort_count_q != '1))
      abort_count_d = abort_count_q + 32'd1;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      skip_count_q  <= '0;
      abort_count_q <= '0;
    end else begin
      skip_count_q  <= skip_count_d;
      abort_count_q <= abort_count_d;
    end
  end

  assign skip_count  = skip_count_q;
  assign abort_count = abort_count_q;
`endif

endmodule

// File: tb/tb_sparce_psru.sv
// Directed self-checking bench for sparce_psru; stats ports follow SPARCE_PSRU_STATS_EN.
module tb_sparce_psru;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic [31:0] pc = '0;
  logic        sasa_hit = 1'b0;
  logic [4:0]  sasa_rs1_in = '0;
  logic [4:0]  sasa_rs2_in = '0;
  logic        sasa_cond = 1'b0;
  logic [4:0]  sasa_skip_cnt = '0;
  logic        inflight_valid = 1'b0;
  logic [4:0]  inflight_rd = '0;
  logic        rs1_sparsity = 1'b0;
  logic        rs2_sparsity = 1'b0;
  logic        flush = 1'b0;
  logic        skip_ack = 1'b0;
  logic [4:0]  sasa_rs1;
  logic [4:0]  sasa_rs2;
  logic        skip;
  logic [31:0] skip_target;
  logic        busy;
`ifdef SPARCE_PSRU_STATS_EN
  logic [31:0] skip_count;
  logic [31:0] abort_count;
  int          exp_skips = 0;
`endif

  int compared = 0;
  int mismatched = 0;

  always #5 CLK = ~CLK;

  sparce_psru #(.MAX_WAIT(3), .SKIP_W(5)) dut (
    .CLK            (CLK),
    .nRST           (nRST),
    .pc             (pc),
    .sasa_hit       (sasa_hit),
    .sasa_rs1_in    (sasa_rs1_in),
    .sasa_rs2_in    (sasa_rs2_in),
    .sasa_cond      (sasa_cond),
    .sasa_skip_cnt  (sasa_skip_cnt),
    .inflight_valid (inflight_valid),
    .inflight_rd    (inflight_rd),
    .rs1_sparsity   (rs1_sparsity),
    .rs2_sparsity   (rs2_sparsity),
    .flush          (flush),
    .skip_ack       (skip_ack),
    .sasa_rs1       (sasa_rs1),
    .sasa_rs2       (sasa_rs2),
    .skip           (skip),
    .skip_target    (skip_target),
    .busy           (busy)
`ifdef SPARCE_PSRU_STATS_EN
    ,
    .skip_count     (skip_count),
    .abort_count    (abort_count)
`endif
  );

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Presents a SASA hit for one edge; returns in the CHECK cycle.
  task automatic start_hit(input logic [31:0] p, input logic [4:0] r1, input logic [4:0] r2,
                           input logic c, input logic [4:0] n);
    pc = p; sasa_rs1_in = r1; sasa_rs2_in = r2; sasa_cond = c; sasa_skip_cnt = n;
    sasa_hit = 1'b1;
    step();
    sasa_hit = 1'b0;
  endtask

  task automatic ack_redirect();
    skip_ack = 1'b1;
    step();
    skip_ack = 1'b0;
`ifdef SPARCE_PSRU_STATS_EN
    exp_skips++;
`endif
  endtask

  task automatic test_reset();
    #1;
    compared++; if (skip !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_skip: got %b want 0", skip); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    compared++; if (skip_target !== 32'h0) begin mismatched++; $display("[TB] FAIL reset_target: got %h want 0", skip_target); end
    compared++; if ({sasa_rs1, sasa_rs2} !== 10'h0) begin mismatched++; $display("[TB] FAIL reset_rs: got %0d/%0d want 0/0", sasa_rs1, sasa_rs2); end
    step();
    nRST = 1'b1;
    step();
  endtask

  task automatic test_basic_skip();
    rs1_sparsity = 1'b1; rs2_sparsity = 1'b1;
    start_hit(32'h100, 5'd5, 5'd6, 1'b1, 5'd3);
    compared++; if ({busy, skip} !== 2'b10) begin mismatched++; $display("[TB] FAIL basic_check_state: got busy/skip %b%b want 10", busy, skip); end
    compared++; if ({sasa_rs1, sasa_rs2} !== {5'd5, 5'd6}) begin mismatched++; $display("[TB] FAIL basic_rs_out: got %0d/%0d want 5/6", sasa_rs1, sasa_rs2); end
    step();
    compared++; if (skip !== 1'b1) begin mismatched++; $display("[TB] FAIL basic_skip: got %b want 1", skip); end
    compared++; if (skip_target !== 32'h110) begin mismatched++; $display("[TB] FAIL basic_target: got %h want 00000110", skip_target); end
    step();
    compared++; if ({skip, skip_target} !== {1'b1, 32'h110}) begin mismatched++; $display("[TB] FAIL basic_hold: got %b %h want 1 00000110", skip, skip_target); end
    ack_redirect();
    compared++; if ({busy, skip} !== 2'b00) begin mismatched++; $display("[TB] FAIL basic_after_ack: got busy/skip %b%b want 00", busy, skip); end
  endtask

  task automatic test_condition();
    rs1_sparsity = 1'b1; rs2_sparsity = 1'b0;
    start_hit(32'h100, 5'd5, 5'd6, 1'b1, 5'd3);
    step();
    compared++; if ({busy, skip} !== 2'b00) begin mismatched++; $display("[TB] FAIL cond_and_noskip: got busy/skip %b%b want 00", busy, skip); end
    start_hit(32'h100, 5'd5, 5'd6, 1'b0, 5'd3);
    step();
    compared++; if ({skip, skip_target} !== {1'b1, 32'h110}) begin mismatched++; $display("[TB] FAIL cond_or_skip: got %b %h want 1 00000110", skip, skip_target); end
    ack_redirect();
  endtask

  task automatic test_wait();
    rs1_sparsity = 1'b1; rs2_sparsity = 1'b1;
    inflight_valid = 1'b1; inflight_rd = 5'd5;
    start_hit(32'h100, 5'd5, 5'd6, 1'b1, 5'd3);
    step();
    compared++; if ({busy, skip} !== 2'b10) begin mismatched++; $display("[TB] FAIL wait_first: got busy/skip %b%b want 10", busy, skip); end
    step();
    inflight_valid = 1'b0;
    compared++; if ({busy, skip} !== 2'b10) begin mismatched++; $display("[TB] FAIL wait_second: got busy/skip %b%b want 10", busy, skip); end
    step();
    compared++; if ({skip, skip_target} !== {1'b1, 32'h110}) begin mismatched++; $display("[TB] FAIL wait_redirect: got %b %h want 1 00000110", skip, skip_target); end
    ack_redirect();
    inflight_valid = 1'b1;
    start_hit(32'h100, 5'd5, 5'd6, 1'b1, 5'd3);
    step(); step(); step();
    compared++; if ({busy, skip} !== 2'b10) begin mismatched++; $display("[TB] FAIL wait_last: got busy/skip %b%b want 10", busy, skip); end
    step();
    compared++; if ({busy, skip} !== 2'b00) begin mismatched++; $display("[TB] FAIL wait_abort: got busy/skip %b%b want 00", busy, skip); end
`ifdef SPARCE_PSRU_STATS_EN
    compared++; if (abort_count !== 32'd1) begin mismatched++; $display("[TB] FAIL abort_count: got %0d want 1", abort_count); end
`endif
    // x0 as a source never hazards, even with a valid in-flight write to rd 0.
    inflight_rd = 5'd0;
    start_hit(32'h200, 5'd0, 5'd7, 1'b1, 5'd1);
    step();
    compared++; if ({skip, skip_target} !== {1'b1, 32'h208}) begin mismatched++; $display("[TB] FAIL x0_nohazard: got %b %h want 1 00000208", skip, skip_target); end
    ack_redirect();
    inflight_valid = 1'b0;
  endtask

  task automatic test_wrap();
    rs1_sparsity = 1'b1; rs2_sparsity = 1'b1;
    start_hit(32'hFFFF_FFF8, 5'd1, 5'd2, 1'b1, 5'd2);
    step();
    compared++; if ({skip, skip_target} !== {1'b1, 32'h4}) begin mismatched++; $display("[TB] FAIL wrap_target: got %b %h want 1 00000004", skip, skip_target); end
    ack_redirect();
    start_hit(32'hFFFF_FFF8, 5'd1, 5'd2, 1'b1, 5'd0);
    step();
    compared++; if ({busy, skip} !== 2'b00) begin mismatched++; $display("[TB] FAIL zero_cnt: got busy/skip %b%b want 00", busy, skip); end
  endtask

  task automatic test_flush();
    rs1_sparsity = 1'b1; rs2_sparsity = 1'b1;
    start_hit(32'h100, 5'd5, 5'd6, 1'b1, 5'd3);
    step();
    flush = 1'b1; skip_ack = 1'b1;
    #1;
    compared++; if (skip !== 1'b0) begin mismatched++; $display("[TB] FAIL flush_mask: got %b want 0", skip); end
    step();
    flush = 1'b0; skip_ack = 1'b0;
    compared++; if ({busy, skip} !== 2'b00) begin mismatched++; $display("[TB] FAIL flush_idle: got busy/skip %b%b want 00", busy, skip); end
`ifdef SPARCE_PSRU_STATS_EN
    compared++; if (skip_count !== 32'(exp_skips)) begin mismatched++; $display("[TB] FAIL skip_count: got %0d want %0d", skip_count, exp_skips); end
`endif
  endtask

  task automatic test_back_to_back();
    rs1_sparsity = 1'b1; rs2_sparsity = 1'b1;
    start_hit(32'h100, 5'd5, 5'd6, 1'b1, 5'd3);
    pc = 32'h400; sasa_rs1_in = 5'd9; sasa_rs2_in = 5'd10; sasa_skip_cnt = 5'd1; sasa_hit = 1'b1;
    step();
    sasa_hit = 1'b0;
    compared++; if ({skip, skip_target} !== {1'b1, 32'h110}) begin mismatched++; $display("[TB] FAIL busy_hit_dropped: got %b %h want 1 00000110", skip, skip_target); end
    compared++; if ({sasa_rs1, sasa_rs2} !== {5'd5, 5'd6}) begin mismatched++; $display("[TB] FAIL busy_hit_rs: got %0d/%0d want 5/6", sasa_rs1, sasa_rs2); end
    #2;
    nRST = 1'b0;
    #1;
    compared++; if ({skip, busy} !== 2'b00) begin mismatched++; $display("[TB] FAIL async_reset_ctl: got skip/busy %b%b want 00", skip, busy); end
    compared++; if ({sasa_rs1, sasa_rs2, skip_target} !== 42'h0) begin mismatched++; $display("[TB] FAIL async_reset_data: got %0d/%0d %h want 0/0 0", sasa_rs1, sasa_rs2, skip_target); end
    step();
    nRST = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_basic_skip();
    test_condition();
    test_wait();
    test_wrap();
    test_flush();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/sparce_psru.md
Name: sparce_psru

Overview:
- Pre-identify-and-skip redundancy unit: the SparCE decision stage directly downstream of the sparsity register file.
- On a SASA table hit at fetch, it latches the entry and drives the entry's source register indices to the SpRF.
- It then evaluates the returned rs1/rs2 sparsity bits against the entry condition and issues a fetch redirect past the redundant instructions.
- It waits a bounded number of cycles while an in-flight instruction still owes a sparsity writeback to a source register.

Parameters:
- MAX_WAIT, 3: max cycles spent in WAIT before the decision is abandoned; 0 means abort immediately on a hazard.
- SKIP_W, 5: width of the SASA skip-count field.

Ports:
- CLK  input  1  clock
- nRST  input  1  reset, asynchronous, active-low
- pc  input  32  fetch PC of the instruction that hit the SASA table
- sasa_hit  input  1  SASA entry valid for pc this cycle
- sasa_rs1_in  input  5  entry source register 1
- sasa_rs2_in  input  5  entry source register 2
- sasa_cond  input  1  1 = both sources must be sparse, 0 = either source
- sasa_skip_cnt  input  SKIP_W  number of instructions to skip after pc
- inflight_valid  input  1  an instruction between decode and writeback will write rd
- inflight_rd  input  5  that instruction's destination register
- rs1_sparsity  input  1  SpRF sparsity of sasa_rs1
- rs2_sparsity  input  1  SpRF sparsity of sasa_rs2
- flush  input  1  pipeline flush or redirect from elsewhere; cancels the decision
- skip_ack  input  1  fetch accepted the skip redirect
- sasa_rs1  output  5  register index sent to SpRF
- sasa_rs2  output  5  register index sent to SpRF
- skip  output  1  redirect request
- skip_target  output  32  redirect PC
- busy  output  1  state != IDLE

Behaviour:
- Reset: state IDLE; all latched fields 0; sasa_rs1 = sasa_rs2 = 0; skip = 0; skip_target = 0; busy = 0.
- Clock and reset: one clock, CLK; reset is asynchronous and active-low on nRST.
- States: IDLE, CHECK, WAIT, REDIRECT.
- IDLE:
  - On sasa_hit & !flush, latch pc, rs1, rs2, cond and skip_cnt at the edge, then go to CHECK.
  - sasa_rs1 and sasa_rs2 are driven from the latched fields, so the SpRF lookup is one cycle after the hit.
- Hazard definition: hazard = inflight_valid & (inflight_rd != 0) & (inflight_rd == lrs1 | inflight_rd == lrs2).
  - A writeback in the same cycle is not a hazard, because the SpRF bypasses it.
- Evaluation: match = cond ? (rs1_sparsity & rs2_sparsity) : (rs1_sparsity | rs2_sparsity).
- CHECK:
  - Hazard with MAX_WAIT > 0: go to WAIT and set wait_cnt = 1.
  - Hazard with MAX_WAIT == 0: go to IDLE.
  - No hazard, match and skip_cnt != 0: go to REDIRECT.
  - No hazard otherwise: go to IDLE.
- WAIT:
  - Each cycle, re-test the hazard.
  - Hazard clear: evaluate exactly as in CHECK.
  - Hazard still set and wait_cnt == MAX_WAIT: go to IDLE (abandoned).
  - Hazard still set otherwise: increment wait_cnt.
- REDIRECT:
  - skip = 1 and skip_target = lpc + ((skip_cnt + 1) << 2), truncated mod 2^32 (wraps past 0xFFFFFFFC).
  - Held stable until skip_ack; on skip_ack go to IDLE, and skip drops the next cycle.
  - skip_ack outside REDIRECT is ignored.
- flush:
  - In any state, forces IDLE at the next edge.
  - skip is combinationally masked in the flush cycle (skip = REDIRECT & !flush).
  - flush with skip_ack in the same cycle counts as a flush; no redirect is taken.
- sasa_hit while busy is dropped; there is no queue.
- skip_cnt == 0 never redirects.
- Register x0 as a source: the SpRF returns sparse; no hazard is possible.
- Mid-operation reset returns all state to reset values immediately.

Optional Feature:
- Macro: SPARCE_PSRU_STATS_EN.
- With the macro defined:
  - Extra output skip_count[31:0] increments on each REDIRECT & skip_ack & !flush.
  - Extra output abort_count[31:0] increments on each WAIT timeout abort.
  - Both counters saturate at 0xFFFFFFFF and reset to 0.
- Without the macro, neither port nor the counter logic exists.

Decomposition:
- Shared package sparce_pkg:
  - psru_state_t enum {IDLE, CHECK, WAIT, REDIRECT}.
  - sasa_entry_t struct {rs1, rs2, cond, skip_cnt}.
  - Constant SPARCE_INSTR_BYTES = 4.
- Optional sub-module sparce_psru_hazard: the combinational hazard comparator, reusable when more in-flight stages are added later.

Test Plan:
- Hit at pc = 0x100, rs1 = 5, rs2 = 6, cond = 1, cnt = 3, both sparse, no hazard: skip asserts 2 cycles after the hit, target = 0x110, held until skip_ack, then IDLE.
- Same entry with rs2_sparsity = 0: cond = 1 gives no skip and IDLE after CHECK; cond = 0 gives skip to 0x110.
- inflight_rd = 5 valid for 2 cycles, MAX_WAIT = 3: WAIT for 2 cycles, then redirect. Held for 4 cycles: abort to IDLE with no skip (abort_count = 1 if stats enabled).
- pc = 0xFFFFFFF8, cnt = 2: target = 0x00000004. cnt = 0: no skip.
- flush asserted in REDIRECT together with skip_ack: skip low that cycle, IDLE next, no skip_count increment.
- sasa_hit during CHECK is ignored. nRST asserted while in REDIRECT: skip, busy and sasa_rs1/rs2 go to 0 asynchronously.
